can_rx_fifo: RTL and testbench
==============================

CAN_RX_FIFO -- requirements
Module: can_rx_fifo

Interface
REQ-001 Parameter: DEPTH, default 16, number of 128-bit message entries; power of two, 2..64.
REQ-002 i_sys_clk  input  1  system clock; all logic on rising edge.
REQ-003 i_reset  input  1  reset i_reset, synchronous, active-high.
REQ-004 i_rx_w_en  input  1  one-cycle write strobe from acceptance filter.
REQ-005 i_rx_fifo_w_data  input  128  message: [127:96] ID, [95:64] DLC, [63:32] DW1, [31:0] DW2.
REQ-006 o_rx_full  output  1  FIFO full, fed back to acceptance filter.
REQ-007 i_rx_r_en  input  1  one-cycle 32-bit word read strobe from register interface.
REQ-008 o_rx_r_data  output  32  current head word.
REQ-009 o_rx_empty  output  1  no complete entry stored.
REQ-010 i_rx_flush  input  1  one-cycle flush of all entries.
REQ-011 i_rx_wm  input  $clog2(DEPTH)  fill watermark; 0 disables.
REQ-012 o_rx_fill  output  $clog2(DEPTH)+1  stored entry count.
REQ-013 o_rxok  output  1  one-cycle pulse per accepted write.
REQ-014 o_rxofl  output  1  one-cycle pulse per dropped write.
REQ-015 o_rxwmfll  output  1  level: watermark reached.

Function
REQ-016 Write and read pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH; count SHALL be $clog2(DEPTH)+1 bits.
REQ-017 A write with count < DEPTH SHALL store i_rx_fifo_w_data at the write pointer, increment it, and pulse o_rxok the next cycle.
REQ-018 A write with count == DEPTH at the cycle start SHALL be dropped even if the same cycle completes a pop; o_rxofl pulses the next cycle and contents are unchanged.
REQ-019 The read side SHALL hold a 2-bit word index: WORD_ID=0, WORD_DLC=1, WORD_DW1=2, WORD_DW2=3.
REQ-020 o_rx_r_data SHALL be combinational: word selected by the word index from the entry at the read pointer (first-word fall-through); 32'h0 when empty.
REQ-021 i_rx_r_en while not empty SHALL advance the word index; i_rx_r_en at WORD_DW2 SHALL return the index to WORD_ID, increment the read pointer and decrement count (pop).
REQ-022 i_rx_r_en while empty SHALL be ignored; no state change.
REQ-023 Accepted write and pop in the same cycle SHALL leave count unchanged and move both pointers.
REQ-024 o_rx_full = (count == DEPTH); o_rx_empty = (count == 0); o_rx_fill = count; all derived from registers.
REQ-025 o_rxwmfll = (i_rx_wm != 0) && (count >= i_rx_wm).
REQ-026 i_rx_flush SHALL clear pointers, count and word index next cycle, overriding a same-cycle write and read; no o_rxok or o_rxofl pulse is generated for that cycle.
REQ-027 Memory contents SHALL NOT be cleared by reset or flush; entry visibility is governed only by count.

Reset
REQ-028 While i_reset is high: pointers, count and word index = 0; o_rxok = 0; o_rxofl = 0; o_rx_empty = 1; o_rx_full = 0; o_rx_fill = 0; o_rx_r_data = 0; o_rxwmfll = 0.
REQ-029 Reset mid-message-read SHALL discard the partial read; the first read after reset returns WORD_ID of the next written entry.
REQ-030 Reset SHALL take priority over flush, write and read.

Structure
REQ-031 The word-index enum (WORD_ID..WORD_DW2) and field bit-offset constants SHALL reside in shared package can_pkg.
REQ-032 Storage SHALL be a separate sub-module can_rx_fifo_mem: 128-bit wide, DEPTH entries, one synchronous write port, one asynchronous read port.

Verification
REQ-033 Write entry 128'h00000123_00000008_DEADBEEF_CAFEF00D, then four reads -> o_rx_r_data 32'h00000123, 32'h00000008, 32'hDEADBEEF, 32'hCAFEF00D; o_rx_empty = 1 after the fourth read.
REQ-034 DEPTH=16: 17 writes -> o_rx_full = 1 after the 16th; the 17th produces one o_rxofl pulse; o_rx_fill = 16.
REQ-035 Full FIFO, write in the same cycle as the fourth-word read -> write dropped, o_rxofl pulses, o_rx_fill = 15.
REQ-036 i_rx_wm = 4: 3 writes -> o_rxwmfll = 0; 4th write -> o_rxwmfll = 1; one complete pop -> o_rxwmfll = 0.
REQ-037 5 writes, 2 word reads, then i_rx_flush asserted with a same-cycle write -> o_rx_empty = 1, o_rx_fill = 0, no o_rxok; the next write reads back WORD_ID first.
REQ-038 Reads while empty, then 3 writes, then 4 pops, then DEPTH further writes -> pointers wrap, data matches write order, and reads while empty leave o_rx_fill unchanged.

Source files
------------

// File: rtl/can_pkg.sv
// Shared CAN receive definitions: message layout and read-side word index.
package can_pkg;

   localparam int unsigned MSG_W   = 128;
   localparam int unsigned WORD_W  = 32;

   // Bit offsets of each 32-bit field inside a stored message
   localparam int unsigned ID_LSB  = 96;
   localparam int unsigned DLC_LSB = 64;
   localparam int unsigned DW1_LSB = 32;
   localparam int unsigned DW2_LSB = 0;

   typedef enum logic [1:0] {
      WORD_ID  = 2'd0,
      WORD_DLC = 2'd1,
      WORD_DW1 = 2'd2,
      WORD_DW2 = 2'd3
   } word_e;

   // Extract the 32-bit field addressed by the word index
   function automatic logic [WORD_W-1:0] word_sel(input logic [MSG_W-1:0] msg,
                                                  input word_e           idx);
      logic [WORD_W-1:0] w;
      case (idx)
         WORD_ID:  w = msg[ID_LSB  +: WORD_W];
         WORD_DLC: w = msg[DLC_LSB +: WORD_W];
         WORD_DW1: w = msg[DW1_LSB +: WORD_W];
         WORD_DW2: w = msg[DW2_LSB +: WORD_W];
         default:  w = '0;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/can_rx_fifo_mem.sv
// Message storage: one synchronous write port, one asynchronous read port, no reset.
module can_rx_fifo_mem
   import can_pkg::*;
#(
   parameter int unsigned DEPTH = 16
)
(
   input  logic                       i_sys_clk,
   input  logic                       i_w_en,
   input  logic [$clog2(DEPTH)-1:0]   i_w_addr,
   input  logic [MSG_W-1:0]           i_w_data,
   input  logic [$clog2(DEPTH)-1:0]   i_r_addr,
   output logic [MSG_W-1:0]           o_r_data
);

   logic [MSG_W-1:0] r_mem [DEPTH];

   // Store an accepted message
   always_ff @(posedge i_sys_clk) begin
      if (i_w_en) begin
         r_mem[i_w_addr] <= i_w_data;
      end
   end

   assign o_r_data = r_mem[i_r_addr];

endmodule

// File: rtl/can_rx_fifo.sv
// CAN receive FIFO: 128-bit messages written whole, read back as four 32-bit words.
module can_rx_fifo
   import can_pkg::*;
#(
   parameter int unsigned DEPTH = 16
)
(
   input  logic                       i_sys_clk,
   input  logic                       i_reset,
   input  logic                       i_rx_w_en,
   input  logic [MSG_W-1:0]           i_rx_fifo_w_data,
   output logic                       o_rx_full,
   input  logic                       i_rx_r_en,
   output logic [WORD_W-1:0]          o_rx_r_data,
   output logic                       o_rx_empty,
   input  logic                       i_rx_flush,
   input  logic [$clog2(DEPTH)-1:0]   i_rx_wm,
   output logic [$clog2(DEPTH):0]     o_rx_fill,
   output logic                       o_rxok,
   output logic                       o_rxofl,
   output logic                       o_rxwmfll
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   word_e            r_word;
   word_e            w_word_nxt;
   logic             r_rxok;
   logic             r_rxofl;

   logic             w_empty;
   logic             w_full;
   logic             w_rd_accept;
   logic             w_pop;
   logic             w_wr_accept;
   logic             w_wr_drop;
   logic             w_mem_we;
   logic [MSG_W-1:0] w_mem_rdata;

   assign w_empty     = (r_count == '0);
   assign w_full      = (r_count == CW'(DEPTH));
   assign w_rd_accept = i_rx_r_en && !w_empty;
   // Fullness is judged at cycle start, so a same-cycle pop never frees room
   assign w_wr_accept = i_rx_w_en && !w_full;
   assign w_wr_drop   = i_rx_w_en &&  w_full;
   assign w_mem_we    = w_wr_accept && !i_reset && !i_rx_flush;

   can_rx_fifo_mem #(
      .DEPTH (DEPTH)
   ) u_mem (
      .i_sys_clk (i_sys_clk),
      .i_w_en    (w_mem_we),
      .i_w_addr  (r_wr_ptr),
      .i_w_data  (i_rx_fifo_w_data),
      .i_r_addr  (r_rd_ptr),
      .o_r_data  (w_mem_rdata)
   );

   // Word-index state register; flush discards a partially read message
   always_ff @(posedge i_sys_clk) begin
      if (i_reset || i_rx_flush) begin
         r_word <= WORD_ID;
      end else begin
         r_word <= w_word_nxt;
      end
   end

   // Word-index next state: step through the four words on each accepted read
   always_comb begin
      w_word_nxt = r_word;
      if (w_rd_accept) begin
         case (r_word)
            WORD_ID:  w_word_nxt = WORD_DLC;
            WORD_DLC: w_word_nxt = WORD_DW1;
            WORD_DW1: w_word_nxt = WORD_DW2;
            WORD_DW2: w_word_nxt = WORD_ID;
            default:  w_word_nxt = WORD_ID;
         endcase
      end
   end

   // Word-index output: reading the last word retires the head entry
   always_comb begin
      w_pop = 1'b0;
      if (w_rd_accept && (r_word == WORD_DW2)) begin
         w_pop = 1'b1;
      end
   end

   // Pointers, occupancy count and status pulses
   always_ff @(posedge i_sys_clk) begin
      if (i_reset || i_rx_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_rxok   <= 1'b0;
         r_rxofl  <= 1'b0;
      end else begin
         if (w_wr_accept) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         r_count <= r_count + CW'(w_wr_accept) - CW'(w_pop);
         r_rxok  <= w_wr_accept;
         r_rxofl <= w_wr_drop;
      end
   end

   // Status is forced to its idle values for as long as reset is held
   assign o_rx_full   = !i_reset && w_full;
   assign o_rx_empty  =  i_reset || w_empty;
   assign o_rx_fill   =  i_reset ? '0 : r_count;
   assign o_rxok      = !i_reset && r_rxok;
   assign o_rxofl     = !i_reset && r_rxofl;
   assign o_rxwmfll   = !i_reset && (i_rx_wm != '0) && (r_count >= CW'(i_rx_wm));
   assign o_rx_r_data = (i_reset || w_empty) ? '0 : word_sel(w_mem_rdata, r_word);

endmodule

// File: tb/tb_can_rx_fifo.sv
// Scoreboard bench for can_rx_fifo: directed scenarios then random traffic vs a queue model.
module tb_can_rx_fifo;

   localparam int unsigned DEPTH = 16;
   localparam int unsigned AW    = $clog2(DEPTH);
   localparam int unsigned CW    = AW + 1;

   typedef struct {
      logic [31:0]   rdata;
      logic [CW-1:0] fill;
      logic          empty;
      logic          full;
      logic          wmfll;
      logic          ok;
      logic          ofl;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          w_en;
   logic [127:0]  w_data;
   logic          r_en;
   logic          flush;
   logic [AW-1:0] wm;
   logic          full_o, empty_o, ok_o, ofl_o, wmfll_o;
   logic [31:0]   rdata_o;
   logic [CW-1:0] fill_o;

   int            total = 0;
   int            bad   = 0;
   exp_t          sb[$];

   // Reference model: queue of whole messages, word position, pending pulses
   logic [127:0]  mq[$];
   int            widx  = 0;
   logic          m_ok  = 1'b0;
   logic          m_ofl = 1'b0;
   logic [AW-1:0] wm_sel = '0;

   always #5 clk = ~clk;

   can_rx_fifo #(.DEPTH(DEPTH)) dut (
      .i_sys_clk        (clk),
      .i_reset          (rst),
      .i_rx_w_en        (w_en),
      .i_rx_fifo_w_data (w_data),
      .o_rx_full        (full_o),
      .i_rx_r_en        (r_en),
      .o_rx_r_data      (rdata_o),
      .o_rx_empty       (empty_o),
      .i_rx_flush       (flush),
      .i_rx_wm          (wm),
      .o_rx_fill        (fill_o),
      .o_rxok           (ok_o),
      .o_rxofl          (ofl_o),
      .o_rxwmfll        (wmfll_o)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Monitor: compare the DUT's presented outputs against the oldest expectation
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("rdata", 64'(rdata_o), 64'(e.rdata));
            chk("fill",  64'(fill_o),  64'(e.fill));
            chk("empty", 64'(empty_o), 64'(e.empty));
            chk("full",  64'(full_o),  64'(e.full));
            chk("wmfll", 64'(wmfll_o), 64'(e.wmfll));
            chk("rxok",  64'(ok_o),    64'(e.ok));
            chk("rxofl", 64'(ofl_o),   64'(e.ofl));
         end
      end
   end

   // One clock: drive inputs, record what the DUT must show now, advance the model
   task automatic cyc(input logic w, input logic [127:0] d, input logic r,
                      input logic fl, input logic rs);
      exp_t        e;
      int          n;
      logic [127:0] head;
      @(negedge clk);
      rst = rs; w_en = w; w_data = d; r_en = r; flush = fl; wm = wm_sel;
      n = mq.size();
      if (rs) begin
         e = '{rdata: 32'h0, fill: '0, empty: 1'b1, full: 1'b0, wmfll: 1'b0, ok: 1'b0, ofl: 1'b0};
      end else begin
         head    = (n > 0) ? mq[0] : 128'h0;
         e.rdata = (n > 0) ? 32'(head >> (32 * (3 - widx))) : 32'h0;
         e.fill  = CW'(n);
         e.empty = (n == 0);
         e.full  = (n == int'(DEPTH));
         e.wmfll = (wm_sel != 0) && (n >= int'(wm_sel));
         e.ok    = m_ok;
         e.ofl   = m_ofl;
      end
      sb.push_back(e);
      if (rs || fl) begin
         mq.delete();
         widx  = 0;
         m_ok  = 1'b0;
         m_ofl = 1'b0;
      end else begin
         if (r && n > 0) begin
            if (widx == 3) begin
               void'(mq.pop_front());
               widx = 0;
            end else begin
               widx++;
            end
         end
         m_ok  = w && (n < int'(DEPTH));
         m_ofl = w && (n == int'(DEPTH));
         if (m_ok) mq.push_back(d);
      end
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic wr(input int k);
      for (int i = 0; i < k; i++) cyc(1'b1, rnd128(), 1'b0, 1'b0, 1'b0);
   endtask

   task automatic rd(input int k);
      for (int i = 0; i < k; i++) cyc(1'b0, 128'h0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic idle(input int k);
      for (int i = 0; i < k; i++) cyc(1'b0, 128'h0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      rst = 1'b1; w_en = 1'b0; w_data = '0; r_en = 1'b0; flush = 1'b0; wm = '0;

      cyc(1'b0, 128'h0, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 128'h0, 1'b0, 1'b0, 1'b1);

      // Reads while empty are ignored
      rd(3);

      // Single message read back word by word
      cyc(1'b1, 128'h00000123_00000008_DEADBEEF_CAFEF00D, 1'b0, 1'b0, 1'b0);
      rd(4);
      idle(1);

      // Overfill: 17th write is dropped
      wr(17);
      idle(2);

      // Full, write coincides with the pop: still dropped
      rd(3);
      cyc(1'b1, rnd128(), 1'b1, 1'b0, 1'b0);
      idle(2);
      rd(15 * 4);
      idle(1);

      // Watermark at 4
      wm_sel = AW'(4);
      wr(3);
      wr(1);
      idle(1);
      rd(4);
      idle(1);
      rd(12);
      wm_sel = '0;
      idle(1);

      // Flush with same-cycle write and read mid-message
      wr(5);
      rd(2);
      cyc(1'b1, rnd128(), 1'b1, 1'b1, 1'b0);
      idle(1);
      wr(1);
      rd(4);
      idle(1);

      // Pointer wrap
      rd(2);
      wr(3);
      rd(12);
      rd(4);
      wr(DEPTH);
      rd(DEPTH * 4);
      idle(1);

      // Reset during a partial message read
      wr(2);
      rd(2);
      cyc(1'b1, rnd128(), 1'b1, 1'b1, 1'b1);
      wr(1);
      rd(4);
      idle(1);

      // Random traffic
      for (int i = 0; i < 2000; i++) begin
         if (i % 97 == 0) wm_sel = AW'($urandom_range(0, DEPTH - 1));
         cyc(($urandom_range(0, 99) < 45), rnd128(), ($urandom_range(0, 99) < 60),
             ($urandom_range(0, 199) == 0), ($urandom_range(0, 399) == 0));
      end
      idle(2);

      @(negedge clk);
      @(negedge clk);
      #4;
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending expectations expected 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
